// File: rtl/sync_fifo_prog_flags_pkg.sv
// Shared constants and helpers for the programmable-flag FIFO.
// The 4-bit status encoding is common to the fill side (POP_FLAG) and
// the free side (PUSH_FLAG); on the free side the count is the number of free slots.
package pp3_fifo_pkg;

  localparam logic [3:0] FLAG_EMPTY   = 4'd0;
  localparam logic [3:0] FLAG_ALMOST  = 4'd1;
  localparam logic [3:0] FLAG_LT_HALF = 4'd2;
  localparam logic [3:0] FLAG_GE_HALF = 4'd3;
  localparam logic [3:0] FLAG_FULL    = 4'd4;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_prog_flags_flag_gen.sv
// Maps an occupancy-style count (0..DEPTH) plus a threshold onto the 4-bit
// status code and the "almost" bit. The same block serves the fill side
// (count of words) and the free side (count of free slots). Purely combinational.
module fifo_flag_gen
  import pp3_fifo_pkg::*;
#(
  parameter int CW     = 10,
  parameter int DEPTH  = 512,
  parameter int THRESH = 4
) (
  input  logic [CW-1:0] val_i,
  output logic [3:0]    flag_o,
  output logic          almost_o
);

  localparam logic [CW-1:0] THR_C   = CW'(THRESH);
  localparam logic [CW-1:0] HALF_C  = CW'(DEPTH / 2);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // First-match priority encode of the status code.
  always_comb begin
    // NOTE: default assigned first so every path drives flag_o and no latch is inferred.
    flag_o = FLAG_GE_HALF;
    if (val_i == '0)          flag_o = FLAG_EMPTY;
    else if (val_i <= THR_C)  flag_o = FLAG_ALMOST;
    else if (val_i < HALF_C)  flag_o = FLAG_LT_HALF;
    else if (val_i == DEPTH_C) flag_o = FLAG_FULL;
  end

  assign almost_o = (val_i <= THR_C);

endmodule

// File: rtl/sync_fifo_prog_flags.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy output and sticky overflow/underflow flags.
// All status outputs are decoded from the registered count.
module sync_fifo_prog_flags
  import pp3_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 512,
  parameter int REG_RD     = 0,
  parameter int AF_THRESH  = 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                              Clk,
  input  logic                              Rst_n,
  input  logic                              Clk_En,
  input  logic                              Flush,
  input  logic                              PUSH,
  input  logic [DATA_WIDTH-1:0]             DIN,
  input  logic                              POP,
  output logic [DATA_WIDTH-1:0]             DOUT,
  output logic [3:0]                        PUSH_FLAG,
  output logic [3:0]                        POP_FLAG,
  output logic                              Almost_Full,
  output logic                              Almost_Empty,
  output logic [clog2(DATA_DEPTH):0]        Level,
  output logic                              Overflow,
  output logic                              Underflow
);

  localparam int AW = clog2(DATA_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DATA_DEPTH);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q,  count_d;
  logic                  ovf_q,    ovf_d;
  logic                  udf_q,    udf_d;
  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  logic full, empty, push_ok, pop_ok;
  logic [CW-1:0] free_cnt;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A request is only accepted on an enabled, non-flush edge.
  assign push_ok = Clk_En & ~Flush & PUSH & ~full;
  assign pop_ok  = Clk_En & ~Flush & POP  & ~empty;

  // Next-state for pointers, count and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (Clk_En) begin
      if (Flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        ovf_d    = 1'b0;
        udf_d    = 1'b0;
      end else begin
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
        else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
        if (PUSH && full)  ovf_d = 1'b1;
        if (POP  && empty) udf_d = 1'b1;
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge Clk) begin
    // NOTE: the array is deliberately not reset so it maps onto RAM; the count guards stale words.
    if (push_ok) mem_q[wr_ptr_q] <= DIN;
  end

  generate
    if (REG_RD != 0) begin : g_reg_rd
      logic [DATA_WIDTH-1:0] dout_q;

      // Registered read: load the head word on an accepted pop, hold otherwise.
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          dout_q <= '0;
        end else if (Clk_En && Flush) begin
          dout_q <= '0;
        end else if (pop_ok) begin
          dout_q <= mem_q[rd_ptr_q];
        end
      end

      assign DOUT = dout_q;
    end else begin : g_show_ahead
      // Show-ahead: the head word is visible before it is popped.
      assign DOUT = mem_q[rd_ptr_q];
    end
  endgenerate

  assign free_cnt = DEPTH_C - count_q;

  fifo_flag_gen #(
    .CW     (CW),
    .DEPTH  (DATA_DEPTH),
    .THRESH (AE_THRESH)
  ) u_fill_flag (
    .val_i    (count_q),
    .flag_o   (POP_FLAG),
    .almost_o (Almost_Empty)
  );

  fifo_flag_gen #(
    .CW     (CW),
    .DEPTH  (DATA_DEPTH),
    .THRESH (AF_THRESH)
  ) u_free_flag (
    .val_i    (free_cnt),
    .flag_o   (PUSH_FLAG),
    .almost_o (Almost_Full)
  );

  assign Level     = count_q;
  assign Overflow  = ovf_q;
  assign Underflow = udf_q;

endmodule
